// File: rtl/instr_fetch_unit.sv
// Instruction fetch: single-outstanding imem requests feeding a show-ahead prefetch queue.
// Latency: request to if_valid is grant edge + rvalid edge + 1 cycle; redirect flushes in 1 cycle.
// Backpressure: id_ready low fills the queue; fetching pauses (IDLE) when no free slot remains.
module instr_fetch_unit #(
    parameter int                 PC_SIZE     = 32,
    parameter int                 INSTR_WIDTH = 32,
    parameter int                 FIFO_DEPTH  = 4,
    parameter logic [PC_SIZE-1:0] RESET_PC    = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          imem_req,
    output logic [PC_SIZE-1:0]            imem_addr,
    input  logic                          imem_gnt,
    input  logic                          imem_rvalid,
    input  logic [INSTR_WIDTH-1:0]        imem_rdata,
    input  logic                          redirect_valid,
    input  logic [PC_SIZE-1:0]            redirect_pc,
    input  logic                          id_ready,
    output logic                          if_valid,
    output logic [INSTR_WIDTH-1:0]        if_instr,
    output logic [PC_SIZE-1:0]            if_pc_plus1,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_IDLE    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [PC_SIZE-1:0]     fetch_pc;
    logic [PC_SIZE-1:0]     req_pc;

    logic [INSTR_WIDTH-1:0] q_instr [FIFO_DEPTH];
    logic [PC_SIZE-1:0]     q_pc1   [FIFO_DEPTH];
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          wr_ptr;
    logic [CW-1:0]          count;
    logic [CW-1:0]          count_nxt;

    logic                   granted;
    logic                   push;
    logic                   pop;

    // A redirect suppresses both queue operations: the flush wins over any push or pop.
    assign granted   = (state == S_REQ) && imem_gnt;
    assign push      = (state == S_WAIT) && imem_rvalid && !redirect_valid;
    assign pop       = (count != '0) && id_ready && !redirect_valid;
    assign count_nxt = count + CW'(push) - CW'(pop);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one request in flight; a redirect with a request in flight drains it via DISCARD.
    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ: begin
                if (imem_gnt) begin
                    state_nxt = redirect_valid ? S_DISCARD : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect_valid) begin
                        state_nxt = S_REQ;
                    end else if (count_nxt < CW'(FIFO_DEPTH)) begin
                        state_nxt = S_REQ;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else if (redirect_valid) begin
                    state_nxt = S_DISCARD;
                end
            end
            S_IDLE: begin
                if (redirect_valid || (count < CW'(FIFO_DEPTH))) begin
                    state_nxt = S_REQ;
                end
            end
            S_DISCARD: begin
                // The stale response retires the outstanding request even if another
                // redirect lands in the same cycle; fetch_pc already holds the newest target.
                if (imem_rvalid) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    // Outputs: the request line is purely a function of state; the address is the fetch pointer.
    always_comb begin
        imem_req  = (state == S_REQ);
        imem_addr = fetch_pc;
    end

    // Fetch pointer and in-flight request address.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else begin
            if (granted) begin
                req_pc <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if (granted) begin
                fetch_pc <= fetch_pc + 1'b1;
            end
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
        end
    end

    // Queue storage; entries are only observed while occupied, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc1[wr_ptr]   <= req_pc + 1'b1;
        end
    end

    // Show-ahead head; outputs read as zero while the queue is empty.
    always_comb begin
        if_valid    = (count != '0);
        if_instr    = if_valid ? q_instr[rd_ptr] : '0;
        if_pc_plus1 = if_valid ? q_pc1[rd_ptr]   : '0;
        fifo_count  = count;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid, id_ready, if_valid;
    logic [31:0] redirect_pc, if_instr, if_pc_plus1;
    logic [2:0]  fifo_count;

    instr_fetch_unit #(.PC_SIZE(32), .INSTR_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc_plus1(if_pc_plus1), .fifo_count(fifo_count)
    );

    // Narrow-PC instance for address wrap-around.
    logic        req8, gnt8, rv8, rdy8, redir8, ifv8;
    logic [7:0]  addr8, rpc8, pc8;
    logic [15:0] rd8, instr8;
    logic [2:0]  cnt8;

    instr_fetch_unit #(.PC_SIZE(8), .INSTR_WIDTH(16), .FIFO_DEPTH(4), .RESET_PC(8'hFF)) dut8 (
        .clk(clk), .rst(rst),
        .imem_req(req8), .imem_addr(addr8), .imem_gnt(gnt8),
        .imem_rvalid(rv8), .imem_rdata(rd8),
        .redirect_valid(redir8), .redirect_pc(rpc8),
        .id_ready(rdy8), .if_valid(ifv8), .if_instr(instr8),
        .if_pc_plus1(pc8), .fifo_count(cnt8)
    );

    int checks = 0;
    int failures = 0;

    typedef struct packed { logic [31:0] instr; logic [31:0] pc1; } exp_t;
    exp_t        sb[$];
    logic [31:0] exp_next;
    int          n_grant = 0, n_pop = 0, n_redir = 0;
    logic [31:0] first_pop_pc1 = 32'hDEAD_BEEF;

    // Stimulus knobs: gnt_mode 0 random/1 always/2 never; rdy_mode 0 low/1 high/2 random.
    int gnt_mode = 1, rdy_mode = 1, lat_mode = 0, lat_fixed = 0;
    bit redir_en = 1'b0;

    // Memory-model state for the main instance.
    bit          m_pend = 1'b0;
    logic [31:0] m_paddr = '0;
    int          m_lat = 0;

    // Narrow-instance observations.
    bit          pend8 = 1'b0;
    logic [7:0]  pa8 = '0;
    logic [7:0]  g8_addr[$];
    logic [7:0]  p8_pc[$];
    logic [15:0] p8_instr[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [15:0] mem_word8(input logic [7:0] a);
        return {a, ~a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #4;
            if (imem_req) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #4;
            if (if_valid) begin ok = 1'b1; break; end
        end
    endtask

    // Driver + instruction memory: grants, responses after a latency, decode readiness, redirects.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
                id_ready = 1'b0; redirect_valid = 1'b0; m_pend = 1'b0;
            end else begin
                imem_rvalid = 1'b0;
                if (m_pend) begin
                    if (m_lat == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(m_paddr);
                        m_pend      = 1'b0;
                    end else begin
                        m_lat--;
                    end
                end
                case (gnt_mode)
                    1:       imem_gnt = imem_req;
                    2:       imem_gnt = 1'b0;
                    default: imem_gnt = imem_req && ($urandom_range(0, 9) < 7);
                endcase
                if (imem_gnt) begin
                    m_pend  = 1'b1;
                    m_paddr = imem_addr;
                    m_lat   = (lat_mode != 0) ? int'($urandom_range(0, 2)) : lat_fixed;
                end
                case (rdy_mode)
                    0:       id_ready = 1'b0;
                    1:       id_ready = 1'b1;
                    default: id_ready = ($urandom_range(0, 3) != 0);
                endcase
                redirect_valid = 1'b0;
                if (redir_en && ($urandom_range(0, 31) == 0)) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = $urandom;
                end
            end
        end
    end

    // Scoreboard producer: each accepted request (outside a redirect) owes one delivery,
    // at the next consecutive address since the last redirect.
    initial begin
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                sb.delete();
                exp_next = 32'h0;
            end else if (redirect_valid) begin
                sb.delete();
                exp_next = redirect_pc;
                n_redir++;
            end else if (imem_req && imem_gnt) begin
                check("grant_addr", imem_addr, exp_next);
                sb.push_back('{instr: mem_word(imem_addr), pc1: imem_addr + 32'd1});
                exp_next = exp_next + 32'd1;
                n_grant++;
            end
        end
    end

    // Monitor: compare every accepted delivery against the oldest owed entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #3;
            if (!rst) begin
                check("count_bound", 32'(fifo_count <= 3'd4), 32'd1);
                check("valid_vs_count", 32'(if_valid), 32'(fifo_count != 3'd0));
                if (if_valid && id_ready && !redirect_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_delivery_pc", if_pc_plus1, 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        check("deliver_pc1", if_pc_plus1, e.pc1);
                        check("deliver_instr", if_instr, e.instr);
                        if (n_pop == 0) first_pop_pc1 = if_pc_plus1;
                        n_pop++;
                    end
                end
            end
        end
    end

    // Narrow instance: always grant, respond one cycle later, always ready.
    initial begin
        rdy8 = 1'b1; redir8 = 1'b0; rpc8 = '0;
        gnt8 = 1'b0; rv8 = 1'b0; rd8 = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                gnt8 = 1'b0; rv8 = 1'b0; pend8 = 1'b0;
            end else begin
                rv8   = pend8;
                rd8   = mem_word8(pa8);
                pend8 = 1'b0;
                gnt8  = req8;
                if (req8) begin
                    pend8 = 1'b1;
                    pa8   = addr8;
                    g8_addr.push_back(addr8);
                end
                if (ifv8 && rdy8) begin
                    p8_pc.push_back(pc8);
                    p8_instr.push_back(instr8);
                end
            end
        end
    end

    initial begin
        bit ok;
        int g0, p0;
        rst = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        #4;
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_instr", if_instr, 32'd0);
        check("rst_if_pc_plus1", if_pc_plus1, 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst8_imem_addr", 32'(addr8), 32'hFF);
        check("rst8_if_pc_plus1", 32'(pc8), 32'd0);
        rst = 1'b0;

        // First cycle out of reset requests RESET_PC.
        @(negedge clk); #4;
        check("post_rst_req", 32'(imem_req), 32'd1);
        check("post_rst_addr", imem_addr, 32'h0);
        check("post_rst8_req", 32'(req8), 32'd1);
        check("post_rst8_addr", 32'(addr8), 32'hFF);

        // Streaming: gnt always, rvalid the cycle after gnt, decode always ready.
        gnt_mode = 1; rdy_mode = 1; lat_mode = 0; lat_fixed = 0;
        repeat (30) @(negedge clk);
        #4;
        check("stream_first_pc1", first_pop_pc1, 32'd1);
        check("stream_progress", 32'(n_pop >= 10), 32'd1);

        // Decode stalls: queue fills to 4, fetching stops, then drains in order.
        rdy_mode = 0;
        repeat (20) @(negedge clk);
        #4;
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_no_req", 32'(imem_req), 32'd0);
        g0 = n_grant;
        repeat (5) @(negedge clk);
        #4;
        check("full_no_5th_grant", 32'(n_grant), 32'(g0));
        check("full_still_no_req", 32'(imem_req), 32'd0);
        rdy_mode = 1;
        p0 = n_pop;
        repeat (20) @(negedge clk);
        #4;
        check("drain_progress", 32'(n_pop - p0 >= 8), 32'd1);
        check("fetch_resumed", 32'(n_grant > g0), 32'd1);

        // Redirect while waiting on a response.
        lat_fixed = 1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (imem_req && imem_gnt) begin ok = 1'b1; break; end
        end
        check("wait_grant_for_wait_redirect", 32'(ok), 32'd1);
        @(negedge clk); #1;
        check("in_wait_no_req", 32'(imem_req), 32'd0);
        check("in_wait_no_rvalid", 32'(imem_rvalid), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk); #4;
        check("wait_redir_flush_count", 32'(fifo_count), 32'd0);
        check("wait_redir_flush_valid", 32'(if_valid), 32'd0);
        wait_req(ok);
        check("wait_redir_req_seen", 32'(ok), 32'd1);
        check("wait_redir_addr", imem_addr, 32'h40);
        wait_valid(ok);
        check("wait_redir_valid_seen", 32'(ok), 32'd1);
        check("wait_redir_first_pc1", if_pc_plus1, 32'h41);
        check("wait_redir_first_instr", if_instr, mem_word(32'h40));

        // Redirect in the same cycle as a grant.
        lat_fixed = 0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (imem_req && imem_gnt) begin
                redirect_valid = 1'b1; redirect_pc = 32'h100;
                ok = 1'b1;
                break;
            end
        end
        check("grant_redir_seen", 32'(ok), 32'd1);
        @(negedge clk); #4;
        check("discard_no_req", 32'(imem_req), 32'd0);
        check("discard_flush_count", 32'(fifo_count), 32'd0);
        check("discard_flush_valid", 32'(if_valid), 32'd0);
        wait_req(ok);
        check("discard_req_seen", 32'(ok), 32'd1);
        check("discard_next_addr", imem_addr, 32'h100);

        // Memory withholds grant: request and address hold steady, nothing is pushed.
        gnt_mode = 2; rdy_mode = 0;
        @(negedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        wait_req(ok);
        check("nogrant_req_seen", 32'(ok), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #4;
            check("nogrant_req_held", 32'(imem_req), 32'd1);
            check("nogrant_addr_held", imem_addr, 32'h200);
            check("nogrant_no_push", 32'(fifo_count), 32'd0);
        end

        // Randomised traffic with random redirects, then a clean drain.
        gnt_mode = 0; rdy_mode = 2; lat_mode = 1; redir_en = 1'b1;
        p0 = n_pop; g0 = n_redir;
        repeat (3000) @(negedge clk);
        redir_en = 1'b0; gnt_mode = 1; rdy_mode = 1;
        repeat (40) @(negedge clk);
        #4;
        check("random_progress", 32'(n_pop - p0 > 200), 32'd1);
        check("random_redirects", 32'(n_redir - g0 > 20), 32'd1);

        // Narrow PC wraps from 0xFF to 0x00.
        check("w8_grants", 32'(g8_addr.size() >= 2), 32'd1);
        check("w8_pops", 32'(p8_pc.size() >= 2), 32'd1);
        if (g8_addr.size() >= 2) begin
            check("w8_addr0", 32'(g8_addr[0]), 32'hFF);
            check("w8_addr1", 32'(g8_addr[1]), 32'h00);
        end
        if (p8_pc.size() >= 2) begin
            check("w8_pc1_0", 32'(p8_pc[0]), 32'h00);
            check("w8_instr_0", 32'(p8_instr[0]), 32'(mem_word8(8'hFF)));
            check("w8_pc1_1", 32'(p8_pc[1]), 32'h01);
            check("w8_instr_1", 32'(p8_instr[1]), 32'(mem_word8(8'h00)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
